// File: rtl/cm0_acg_ctrl.sv
// cm0_acg_ctrl: multi-channel clock-gate controller with hold-off hysteresis, force-on, idle flag and gated-cycle stats.
module cm0_acg_ctrl #(
  parameter int NCH    = 3,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16,
  parameter int CBAW   = 0,
  parameter int ACG    = 1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              SE,
  input  logic              force_on_i,
  input  logic [NCH-1:0]    ch_en_i,
  input  logic [HOLD_W-1:0] hold_cfg_i,
  output logic [NCH-1:0]    ch_clk_o,
  output logic [NCH-1:0]    ch_gate_en_o,
  output logic              all_idle_o,
  input  logic [3:0]        stat_sel_i,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stat_cnt_o
);
  typedef enum logic [1:0] {OFF, ON, HOLD} state_e;
  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [HOLD_W-1:0] hold_q [NCH];
  logic [HOLD_W-1:0] hold_d [NCH];
  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];
  logic [CNT_W-1:0]  stat_q, stat_d;
  logic              all_idle_q, all_idle_d;
  always_comb begin
    all_idle_d = ~(force_on_i | SE | (|ch_en_i));
    stat_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      if (ch_en_i[i]) begin
        state_d[i] = ON;
        hold_d[i]  = '0;
      end else if (state_q[i] == ON) begin
        state_d[i] = (hold_cfg_i != '0) ? HOLD : OFF;
        hold_d[i]  = hold_cfg_i;
      end else if (state_q[i] == HOLD) begin
        state_d[i] = (hold_q[i] == HOLD_W'(1)) ? OFF : HOLD;
        hold_d[i]  = hold_q[i] - HOLD_W'(1);
      end
      ch_gate_en_o[i] = ch_en_i[i] | (state_q[i] != OFF) | force_on_i | SE;
      all_idle_d      = all_idle_d & (state_q[i] == OFF);
      // clear beats increment; the counter sticks at all-ones
      cnt_d[i] = (stat_clr_i && stat_sel_i == 4'(i)) ? '0 :
                 (!ch_gate_en_o[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      stat_d   = (stat_sel_i == 4'(i)) ? cnt_d[i] : stat_d;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= OFF;
        hold_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      stat_q     <= '0;
      all_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      stat_q     <= stat_d;
      all_idle_q <= all_idle_d;
    end
  end
  assign stat_cnt_o = stat_q;
  assign all_idle_o = all_idle_q;
  for (genvar g = 0; g < NCH; g++) begin : g_acg
    cm0_acg #(.ACG(ACG), .CBAW(CBAW)) u_acg (
      .CLKIN  (hclk),
      .ENABLE (ch_gate_en_o[g]),
      .SE     (SE),
      .CLKOUT (ch_clk_o[g])
    );
  end
endmodule

// cm0_acg: latch-based clock gate; ACG=0 passes the clock, CBAW!=0 uses a plain AND gate model.
module cm0_acg #(
  parameter int ACG  = 1,
  parameter int CBAW = 0
) (
  input  logic CLKIN,
  input  logic ENABLE,
  input  logic SE,
  output logic CLKOUT
);
  logic en_l;
  always_latch if (!CLKIN) en_l = ENABLE | SE;
  assign CLKOUT = (ACG == 0) ? CLKIN : CLKIN & ((CBAW != 0) ? (ENABLE | SE) : en_l);
endmodule
